// File: rtl/sdram_scan_tester.sv
// Write/read-back scan of the byte-wide SDRAM controller user port with an address-derived
// pattern; reports pass/fail LEDs, error count and first failing address.
module sdram_scan_tester #(
  parameter int                    ADDR_WIDTH    = 27,
  parameter int                    DATA_WIDTH    = 8,
  parameter logic [ADDR_WIDTH-1:0] ADDR_LAST     = {ADDR_WIDTH{1'b1}},
  parameter logic [7:0]            SEED          = 8'hA5,
  parameter logic [15:0]           START_DELAY   = 16'd1000,
  parameter logic [15:0]           RD_TIMEOUT    = 16'd255,
  parameter bit                    STOP_ON_ERROR = 1'b1
) (
  input  logic                  clk_66p7m,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  sdram_busy,
  input  logic                  sdram_data_ready,
  input  logic [DATA_WIDTH-1:0] sdram_dout,
  output logic [ADDR_WIDTH-1:0] sdram_address,
  output logic [DATA_WIDTH-1:0] sdram_din,
  output logic                  sdram_write,
  output logic                  sdram_read,
  output logic                  data_correct,
  output logic                  scan_finished,
  output logic                  led_succeed,
  output logic                  led_fault,
  output logic [15:0]           error_count,
  output logic [ADDR_WIDTH-1:0] first_err_addr
);

  typedef enum logic [2:0] {IDLE, W_REQ, W_ACK, W_WAIT, R_REQ, R_WAIT, DONE, FAIL} state_t;

  function automatic logic [DATA_WIDTH-1:0] pat(input logic [ADDR_WIDTH-1:0] a);
    logic [26:0] x;
    logic [7:0]  p;
    x = 27'(a);
    p = x[7:0] ^ x[15:8] ^ x[23:16] ^ {5'b0, x[26:24]} ^ SEED;
    return DATA_WIDTH'(p);
  endfunction

  state_t                state, state_n;
  logic [ADDR_WIDTH-1:0] addr, addr_n;
  logic [15:0]           cnt, cnt_n;
  logic [ADDR_WIDTH-1:0] address_n, first_n;
  logic [DATA_WIDTH-1:0] din_n;
  logic                  write_n, read_n, correct_n, fin_n, succeed_n, fault_n;
  logic [15:0]           err_cnt_n;
  logic                  err, rd_done, last, idle_done, rd_timeout;

  // One counter serves both the post-reset delay and the read timeout.
  assign last       = (addr == ADDR_LAST);
  assign idle_done  = ({1'b0, cnt} + 17'd1) >= {1'b0, START_DELAY};
  assign rd_timeout = ({1'b0, cnt} + 17'd1) >= {1'b0, RD_TIMEOUT};

  always_comb begin
    state_n   = state;
    addr_n    = addr;
    cnt_n     = cnt;
    address_n = sdram_address;
    din_n     = sdram_din;
    write_n   = 1'b0;
    read_n    = 1'b0;
    correct_n = data_correct;
    err_cnt_n = error_count;
    first_n   = first_err_addr;
    fault_n   = led_fault;
    err       = 1'b0;
    rd_done   = 1'b0;
    case (state)
      IDLE: begin
        if (idle_done) begin
          state_n = W_REQ;
          addr_n  = '0;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 16'd1;
        end
      end
      W_REQ: if (!sdram_busy) begin
        write_n   = 1'b1;
        address_n = addr;
        din_n     = pat(addr);
        state_n   = W_ACK;
      end
      // busy is not yet valid the cycle after a request
      W_ACK: state_n = W_WAIT;
      W_WAIT: if (!sdram_busy) begin
        if (last) begin
          addr_n  = '0;
          state_n = R_REQ;
        end else begin
          addr_n  = addr + ADDR_WIDTH'(1);
          state_n = W_REQ;
        end
      end
      R_REQ: if (!sdram_busy) begin
        read_n    = 1'b1;
        address_n = addr;
        cnt_n     = '0;
        state_n   = R_WAIT;
      end
      R_WAIT: begin
        cnt_n = cnt + 16'd1;
        if (sdram_data_ready) begin
          rd_done   = 1'b1;
          correct_n = (sdram_dout == pat(addr));
          err       = (sdram_dout != pat(addr));
        end else if (rd_timeout) begin
          rd_done   = 1'b1;
          correct_n = 1'b0;
          err       = 1'b1;
        end
        if (rd_done) begin
          if (err && STOP_ON_ERROR) state_n = FAIL;
          else if (last)            state_n = DONE;
          else begin
            addr_n  = addr + ADDR_WIDTH'(1);
            state_n = R_REQ;
          end
        end
      end
      DONE, FAIL: if (start) begin
        state_n   = W_REQ;
        addr_n    = '0;
        err_cnt_n = '0;
        first_n   = '0;
        fault_n   = 1'b0;
        correct_n = 1'b1;
      end
      default: state_n = IDLE;
    endcase
    if (err) begin
      if (error_count != 16'hFFFF) err_cnt_n = error_count + 16'd1;
      if (error_count == 16'd0)    first_n   = addr;
      fault_n = 1'b1;
    end
    if (state_n == FAIL) fault_n = 1'b1;
    fin_n     = (state_n == DONE) || (state_n == FAIL);
    succeed_n = (state_n == DONE) && (err_cnt_n == 16'd0);
  end

  always_ff @(posedge clk_66p7m) begin
    if (rst) begin
      state          <= IDLE;
      addr           <= '0;
      cnt            <= '0;
      sdram_address  <= '0;
      sdram_din      <= '0;
      sdram_write    <= 1'b0;
      sdram_read     <= 1'b0;
      data_correct   <= 1'b1;
      scan_finished  <= 1'b0;
      led_succeed    <= 1'b0;
      led_fault      <= 1'b0;
      error_count    <= '0;
      first_err_addr <= '0;
    end else begin
      state          <= state_n;
      addr           <= addr_n;
      cnt            <= cnt_n;
      sdram_address  <= address_n;
      sdram_din      <= din_n;
      sdram_write    <= write_n;
      sdram_read     <= read_n;
      data_correct   <= correct_n;
      scan_finished  <= fin_n;
      led_succeed    <= succeed_n;
      led_fault      <= fault_n;
      error_count    <= err_cnt_n;
      first_err_addr <= first_n;
    end
  end

endmodule

// File: tb/tb_sdram_scan_tester.sv
// Bench for sdram_scan_tester: two instances (stop-on-error / continue) share stimulus,
// each with its own small controller model (busy 3 cycles, read latency ~5).
module tb_sdram_scan_tester;
  localparam int AW = 27;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic          busy [2];
  logic          dready [2];
  logic [DW-1:0] dout [2];
  logic [AW-1:0] address [2];
  logic [DW-1:0] din [2];
  logic          write [2], read [2], data_correct [2], scan_finished [2];
  logic          led_succeed [2], led_fault [2];
  logic [15:0]   error_count [2];
  logic [AW-1:0] first_err_addr [2];

  int errors = 0;
  int checks = 0;

  logic       corrupt_en = 1'b0, drop_en = 1'b0, hold_busy = 1'b0;
  logic [3:0] corrupt_addr = 4'd0, drop_addr = 4'd0;
  logic [7:0] mem [2][16];
  int         bcnt [2], rlat [2];
  logic [3:0] raddr [2];
  int         nwr [2], nrd [2];
  logic [AW-1:0] wlog_a [2][512];
  logic [DW-1:0] wlog_d [2][512];
  logic [AW-1:0] rlog_a [2][512];
  int         rw_both = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    sdram_scan_tester #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ADDR_LAST(27'd15), .SEED(8'hA5),
      .START_DELAY(16'd4), .RD_TIMEOUT(16'd255), .STOP_ON_ERROR(g == 0)
    ) u_dut (
      .clk_66p7m(clk), .rst(rst), .start(start),
      .sdram_busy(busy[g]), .sdram_data_ready(dready[g]), .sdram_dout(dout[g]),
      .sdram_address(address[g]), .sdram_din(din[g]),
      .sdram_write(write[g]), .sdram_read(read[g]),
      .data_correct(data_correct[g]), .scan_finished(scan_finished[g]),
      .led_succeed(led_succeed[g]), .led_fault(led_fault[g]),
      .error_count(error_count[g]), .first_err_addr(first_err_addr[g])
    );
  end

  // Controller model, evaluated on the falling edge so it never races the DUT or the tasks.
  always @(negedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (rst) begin
        busy[g] = 1'b0; dready[g] = 1'b0; dout[g] = '0; bcnt[g] = 0; rlat[g] = 0;
      end else begin
        dready[g] = 1'b0;
        if (bcnt[g] > 0) bcnt[g]--;
        if (rlat[g] > 0) begin
          rlat[g]--;
          if (rlat[g] == 0 && !(drop_en && raddr[g] == drop_addr)) begin
            dready[g] = 1'b1;
            dout[g] = mem[g][raddr[g]] ^ ((corrupt_en && raddr[g] == corrupt_addr) ? 8'h01 : 8'h00);
          end
        end
        if (write[g] && read[g]) rw_both++;
        if (write[g]) begin
          mem[g][address[g][3:0]] = din[g];
          bcnt[g] = 3;
          if (nwr[g] < 512) begin wlog_a[g][nwr[g]] = address[g]; wlog_d[g][nwr[g]] = din[g]; end
          nwr[g]++;
        end
        if (read[g]) begin
          raddr[g] = address[g][3:0];
          rlat[g] = 5;
          bcnt[g] = 3;
          if (nrd[g] < 512) rlog_a[g][nrd[g]] = address[g];
          nrd[g]++;
        end
        busy[g] = (bcnt[g] > 0) || hold_busy;
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic wait_finished(input int budget, output bit ok);
    int n;
    n = 0;
    while (!(scan_finished[0] && scan_finished[1]) && n < budget) begin tick(); n++; end
    ok = scan_finished[0] && scan_finished[1];
  endtask

  task automatic test_reset();
    logic [36:0] req;
    logic [46:0] st;
    rst = 1'b1;
    repeat (3) tick();
    for (int g = 0; g < 2; g++) begin
      req = {address[g], din[g], write[g], read[g]};
      st  = {scan_finished[g], led_succeed[g], led_fault[g], data_correct[g], error_count[g], first_err_addr[g]};
      checks++;
      if (req !== 37'd0) begin errors++; $display("FAIL reset_req[%0d]: got %h expected 0", g, req); end
      checks++;
      if (st !== {4'b0001, 16'd0, 27'd0})
        begin errors++; $display("FAIL reset_status[%0d]: got %h expected %h", g, st, {4'b0001, 16'd0, 27'd0}); end
    end
  endtask

  task automatic test_clean_scan();
    int wb [2], rb [2];
    int n;
    bit ok;
    logic [46:0] st;
    for (int g = 0; g < 2; g++) begin wb[g] = nwr[g]; rb[g] = nrd[g]; end
    rst = 1'b0;
    n = 0;
    while (!write[0] && n < 20) begin tick(); n++; end
    checks++;
    if (n != 5) begin errors++; $display("FAIL start_delay: got %0d cycles expected 5", n); end
    checks++;
    if ({address[0], din[0]} !== {27'd0, 8'hA5})
      begin errors++; $display("FAIL first_write: got %h/%h expected 0/a5", address[0], din[0]); end
    wait_finished(2000, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL clean_finish: scan_finished not reached"); end
    for (int g = 0; g < 2; g++) begin
      st = {scan_finished[g], led_succeed[g], led_fault[g], data_correct[g], error_count[g], first_err_addr[g]};
      checks++;
      if (st !== {4'b1101, 16'd0, 27'd0})
        begin errors++; $display("FAIL clean_status[%0d]: got %h expected %h", g, st, {4'b1101, 16'd0, 27'd0}); end
      checks++;
      if (nwr[g] - wb[g] != 16 || nrd[g] - rb[g] != 16)
        begin errors++; $display("FAIL clean_counts[%0d]: got w=%0d r=%0d expected 16/16", g, nwr[g] - wb[g], nrd[g] - rb[g]); end
      for (int i = 0; i < 16; i++) begin
        checks++;
        if ({wlog_a[g][wb[g] + i], wlog_d[g][wb[g] + i]} !== {27'(i), 8'hA5 ^ 8'(i)})
          begin errors++; $display("FAIL clean_write[%0d][%0d]: got %h/%h expected %h/%h", g, i,
                 wlog_a[g][wb[g] + i], wlog_d[g][wb[g] + i], 27'(i), 8'hA5 ^ 8'(i)); end
        checks++;
        if (rlog_a[g][rb[g] + i] !== 27'(i))
          begin errors++; $display("FAIL clean_read[%0d][%0d]: got %h expected %h", g, i, rlog_a[g][rb[g] + i], 27'(i)); end
      end
    end
  endtask

  task automatic test_mismatch();
    int rb [2];
    bit ok;
    logic [46:0] st, ex;
    for (int g = 0; g < 2; g++) rb[g] = nrd[g];
    corrupt_en = 1'b1; corrupt_addr = 4'd7;
    pulse_start();
    tick();
    checks++;
    if ({write[0], address[0], scan_finished[0]} !== {1'b1, 27'd0, 1'b0})
      begin errors++; $display("FAIL restart_write: got w=%b a=%h sf=%b expected 1/0/0", write[0], address[0], scan_finished[0]); end
    wait_finished(2000, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL mismatch_finish: scan_finished not reached"); end
    for (int g = 0; g < 2; g++) begin
      st = {scan_finished[g], led_succeed[g], led_fault[g], data_correct[g], error_count[g], first_err_addr[g]};
      ex = (g == 0) ? {4'b1010, 16'd1, 27'd7} : {4'b1011, 16'd1, 27'd7};
      checks++;
      if (st !== ex) begin errors++; $display("FAIL mismatch_status[%0d]: got %h expected %h", g, st, ex); end
      checks++;
      if (nrd[g] - rb[g] != ((g == 0) ? 8 : 16))
        begin errors++; $display("FAIL mismatch_reads[%0d]: got %0d expected %0d", g, nrd[g] - rb[g], (g == 0) ? 8 : 16); end
    end
    corrupt_en = 1'b0;
  endtask

  task automatic test_timeout();
    int rb [2];
    int n;
    bit ok;
    logic [46:0] st, ex;
    for (int g = 0; g < 2; g++) rb[g] = nrd[g];
    drop_en = 1'b1; drop_addr = 4'd3;
    pulse_start();
    for (int g = 0; g < 2; g++) begin
      st = {scan_finished[g], led_succeed[g], led_fault[g], data_correct[g], error_count[g], first_err_addr[g]};
      checks++;
      if (st !== {4'b0001, 16'd0, 27'd0})
        begin errors++; $display("FAIL start_clear[%0d]: got %h expected %h", g, st, {4'b0001, 16'd0, 27'd0}); end
    end
    n = 0;
    while (!(read[0] && address[0] == 27'd3) && n < 500) begin tick(); n++; end
    checks++;
    if (!(read[0] && address[0] == 27'd3)) begin errors++; $display("FAIL timeout_read3: read of addr 3 not seen"); end
    n = 0;
    while (data_correct[0] && n < 400) begin tick(); n++; end
    checks++;
    if (n != 255) begin errors++; $display("FAIL timeout_cycles: got %0d expected 255", n); end
    wait_finished(2000, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL timeout_finish: scan_finished not reached"); end
    for (int g = 0; g < 2; g++) begin
      st = {scan_finished[g], led_succeed[g], led_fault[g], data_correct[g], error_count[g], first_err_addr[g]};
      ex = (g == 0) ? {4'b1010, 16'd1, 27'd3} : {4'b1011, 16'd1, 27'd3};
      checks++;
      if (st !== ex) begin errors++; $display("FAIL timeout_status[%0d]: got %h expected %h", g, st, ex); end
      checks++;
      if (nrd[g] - rb[g] != ((g == 0) ? 4 : 16))
        begin errors++; $display("FAIL timeout_reads[%0d]: got %0d expected %0d", g, nrd[g] - rb[g], (g == 0) ? 4 : 16); end
    end
    drop_en = 1'b0;
  endtask

  task automatic test_busy_hold();
    int wb [2], wc [2];
    int n;
    bit ok;
    logic [46:0] st;
    for (int g = 0; g < 2; g++) begin wb[g] = nwr[g]; wc[g] = 0; end
    hold_busy = 1'b1;
    tick();
    pulse_start();
    n = 0;
    repeat (50) begin tick(); if (write[0] || write[1]) n++; end
    checks++;
    if (n != 0) begin errors++; $display("FAIL busy_hold_writes: got %0d expected 0", n); end
    hold_busy = 1'b0;
    repeat (4) begin
      tick();
      for (int g = 0; g < 2; g++) if (write[g]) wc[g]++;
    end
    for (int g = 0; g < 2; g++) begin
      checks++;
      if (wc[g] != 1) begin errors++; $display("FAIL busy_release_pulses[%0d]: got %0d expected 1", g, wc[g]); end
      checks++;
      if ({wlog_a[g][wb[g]], wlog_d[g][wb[g]]} !== {27'd0, 8'hA5})
        begin errors++; $display("FAIL busy_release_data[%0d]: got %h/%h expected 0/a5", g, wlog_a[g][wb[g]], wlog_d[g][wb[g]]); end
    end
    wait_finished(2000, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL busy_finish: scan_finished not reached"); end
    for (int g = 0; g < 2; g++) begin
      st = {scan_finished[g], led_succeed[g], led_fault[g], data_correct[g], error_count[g], first_err_addr[g]};
      checks++;
      if (st !== {4'b1101, 16'd0, 27'd0} || nwr[g] - wb[g] != 16)
        begin errors++; $display("FAIL busy_status[%0d]: got %h w=%0d expected %h w=16", g, st, nwr[g] - wb[g], {4'b1101, 16'd0, 27'd0}); end
    end
  endtask

  task automatic test_rst_midscan();
    int wb [2], rb [2];
    int n;
    bit ok;
    logic [46:0] st;
    pulse_start();
    n = 0;
    while (!read[0] && n < 500) begin tick(); n++; end
    checks++;
    if (!read[0]) begin errors++; $display("FAIL midscan_read: no read request seen"); end
    rst = 1'b1;
    tick(); tick();
    for (int g = 0; g < 2; g++) begin
      st = {scan_finished[g], led_succeed[g], led_fault[g], data_correct[g], error_count[g], first_err_addr[g]};
      checks++;
      if (st !== {4'b0001, 16'd0, 27'd0} || {write[g], read[g]} !== 2'b00)
        begin errors++; $display("FAIL midscan_reset[%0d]: got %h w=%b r=%b expected %h", g, st, write[g], read[g], {4'b0001, 16'd0, 27'd0}); end
      wb[g] = nwr[g]; rb[g] = nrd[g];
    end
    rst = 1'b0;
    n = 0;
    while (!write[0] && n < 20) begin tick(); n++; end
    checks++;
    if (n != 5) begin errors++; $display("FAIL midscan_delay: got %0d cycles expected 5", n); end
    repeat (3) tick();
    pulse_start();
    wait_finished(2000, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL midscan_finish: scan_finished not reached"); end
    for (int g = 0; g < 2; g++) begin
      st = {scan_finished[g], led_succeed[g], led_fault[g], data_correct[g], error_count[g], first_err_addr[g]};
      checks++;
      if (st !== {4'b1101, 16'd0, 27'd0} || nwr[g] - wb[g] != 16 || nrd[g] - rb[g] != 16)
        begin errors++; $display("FAIL midscan_status[%0d]: got %h w=%0d r=%0d expected %h 16/16", g, st, nwr[g] - wb[g], nrd[g] - rb[g], {4'b1101, 16'd0, 27'd0}); end
    end
  endtask

  task automatic test_back_to_back();
    int wb [2], rb [2];
    bit ok;
    logic [46:0] st;
    for (int g = 0; g < 2; g++) begin wb[g] = nwr[g]; rb[g] = nrd[g]; end
    pulse_start();
    checks++;
    if (scan_finished[0] !== 1'b0 || scan_finished[1] !== 1'b0)
      begin errors++; $display("FAIL rerun_clear: got %b%b expected 00", scan_finished[0], scan_finished[1]); end
    wait_finished(2000, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL rerun_finish: scan_finished not reached"); end
    for (int g = 0; g < 2; g++) begin
      st = {scan_finished[g], led_succeed[g], led_fault[g], data_correct[g], error_count[g], first_err_addr[g]};
      checks++;
      if (st !== {4'b1101, 16'd0, 27'd0} || nwr[g] - wb[g] != 16 || nrd[g] - rb[g] != 16)
        begin errors++; $display("FAIL rerun_status[%0d]: got %h w=%0d r=%0d expected %h 16/16", g, st, nwr[g] - wb[g], nrd[g] - rb[g], {4'b1101, 16'd0, 27'd0}); end
    end
    checks++;
    if (rw_both != 0) begin errors++; $display("FAIL read_write_same_cycle: got %0d expected 0", rw_both); end
  endtask

  initial begin
    for (int g = 0; g < 2; g++) begin nwr[g] = 0; nrd[g] = 0; end
    test_reset();
    test_clean_scan();
    test_mismatch();
    test_timeout();
    test_busy_hold();
    test_rst_midscan();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
